// File: rtl/axo_dma_copy_if.sv
// ---------------------------------------------------------------------------
// axo_mem_bus
// Axo memory bus between one initiator and one responder.
//   addr   [31:0]  byte address of the access
//   asize  [1:0]   access size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes
//   re, we         read / write strobes (never both high)
//   wdata  [31:0]  write data, right-justified (low 8n bits significant)
//   rdata  [31:0]  read data, right-justified
//   ready          access completes on the rising edge where ready is high
//   error          qualifies ready: the access faulted
// Modports: CPU (initiator side), MEM (responder side).
// ---------------------------------------------------------------------------
interface axo_mem_bus;
  logic [31:0] addr;
  logic [1:0]  asize;
  logic        re;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        error;

  modport CPU (output addr, asize, re, we, wdata,
               input  rdata, ready, error);
  modport MEM (input  addr, asize, re, we, wdata,
               output rdata, ready, error);
endinterface

// File: rtl/axo_dma_copy.sv
// ---------------------------------------------------------------------------
// axo_dma_copy
// Single-channel memory-copy engine, initiator on the Axo memory bus.
// Moves len_i bytes from src_i to dst_i, one unit per read/write pair, using
// the widest naturally aligned access (4, 2 or 1 byte) that the current
// addresses and remaining length allow.
//
// Optional feature macro: AXO_DMA_FILL_EN
//   defined   : fill_i selects fill mode, writing pattern_i repeatedly to dst
//               without reads.
//   undefined : fill_i / pattern_i are ignored and every transfer is a copy.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_i      one-cycle request, accepted only when idle
//   src_i        source byte address (sampled on accepted start)
//   dst_i        destination byte address (sampled on accepted start)
//   len_i        byte count (sampled on accepted start)
//   fill_i       fill mode select (sampled on accepted start)
//   pattern_i    fill data (sampled on accepted start)
//   busy_o       high while a transfer is in progress
//   done_o       one-cycle pulse on completion or abort
//   error_o      sticky abort flag, cleared by the next accepted start
//   err_addr_o   address of the faulting access
//   bus          axo_mem_bus initiator side
// ---------------------------------------------------------------------------
module axo_dma_copy #(
  parameter int len_bits = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [31:0]         src_i,
  input  logic [31:0]         dst_i,
  input  logic [len_bits-1:0] len_i,
  input  logic                fill_i,
  input  logic [31:0]         pattern_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [31:0]         err_addr_o,
  axo_mem_bus.CPU             bus
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ABORT} state_e;

  state_e              state_q, state_d;
  logic [31:0]         src_q, src_d;
  logic [31:0]         dst_q, dst_d;
  logic [31:0]         data_q, data_d;
  logic [31:0]         err_addr_q, err_addr_d;
  logic [len_bits-1:0] rem_q, rem_d;
  logic [1:0]          asize_q, asize_d;
  logic                error_q, error_d;

  logic                fillStart;
  logic                fillMode;
  logic [31:0]         writeData;

  logic [2:0]          unitBytes;
  logic [31:0]         srcNext;
  logic [31:0]         dstNext;
  logic [len_bits-1:0] remNext;
  logic [1:0]          nextAsize;

  // Widest naturally aligned unit; in fill mode only dst alignment matters.
  function automatic logic [1:0] pickAsize(input logic [31:0]         s,
                                           input logic [31:0]         d,
                                           input logic [len_bits-1:0] r,
                                           input logic                f);
    logic [1:0] sz;
    sz = 2'd0;
    if ((f || s[1:0] == 2'b00) && d[1:0] == 2'b00 && r >= len_bits'(4)) begin
      sz = 2'd2;
    end else if ((f || !s[0]) && !d[0] && r >= len_bits'(2)) begin
      sz = 2'd1;
    end
    return sz;
  endfunction

  // Address/length bookkeeping after the current unit completes; the unit
  // size for the next unit is chosen from these post-increment values.
  assign unitBytes = (asize_q == 2'd2) ? 3'd4 : (asize_q == 2'd1) ? 3'd2 : 3'd1;
  assign srcNext   = src_q + 32'(unitBytes);
  assign dstNext   = dst_q + 32'(unitBytes);
  assign remNext   = rem_q - len_bits'(unitBytes);
  assign nextAsize = pickAsize(srcNext, dstNext, remNext, fillMode);

`ifdef AXO_DMA_FILL_EN
  logic        fill_q, fill_d;
  logic [31:0] pattern_q, pattern_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q    <= 1'b0;
      pattern_q <= '0;
    end else begin
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
    end
  end

  always_comb begin
    fill_d    = fill_q;
    pattern_d = pattern_q;
    if (state_q == IDLE && start_i) begin
      fill_d    = fill_i;
      pattern_d = pattern_i;
    end
  end

  assign fillStart = fill_i;
  assign fillMode  = fill_q;
  assign writeData = fill_q ? pattern_q : data_q;
`else
  logic unusedFill;
  assign unusedFill = ^{fill_i, pattern_i};
  assign fillStart  = 1'b0;
  assign fillMode   = 1'b0;
  assign writeData  = data_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      data_q     <= '0;
      err_addr_q <= '0;
      rem_q      <= '0;
      asize_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      data_q     <= data_d;
      err_addr_q <= err_addr_d;
      rem_q      <= rem_d;
      asize_q    <= asize_d;
      error_q    <= error_d;
    end
  end

  // Bus outputs depend only on registered state, so they hold steady across
  // wait states and drop to zero the instant reset forces IDLE.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    data_d     = data_q;
    err_addr_d = err_addr_q;
    rem_d      = rem_q;
    asize_d    = asize_q;
    error_d    = error_q;
    bus.addr   = '0;
    bus.asize  = '0;
    bus.re     = 1'b0;
    bus.we     = 1'b0;
    bus.wdata  = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_i;
          dst_d   = dst_i;
          rem_d   = len_i;
          error_d = 1'b0;
          asize_d = pickAsize(src_i, dst_i, len_i, fillStart);
          if (len_i == '0)    state_d = DONE;
          else if (fillStart) state_d = WRITE;
          else                state_d = READ;
        end
      end

      READ: begin
        bus.addr  = src_q;
        bus.asize = asize_q;
        bus.re    = 1'b1;
        if (bus.ready) begin
          if (bus.error) begin
            err_addr_d = src_q;
            error_d    = 1'b1;
            state_d    = ABORT;
          end else begin
            // Only the low n bytes are refreshed; upper bytes are don't-care.
            case (asize_q)
              2'd2:    data_d = bus.rdata;
              2'd1:    data_d = {data_q[31:16], bus.rdata[15:0]};
              default: data_d = {data_q[31:8], bus.rdata[7:0]};
            endcase
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        bus.addr  = dst_q;
        bus.asize = asize_q;
        bus.we    = 1'b1;
        bus.wdata = writeData;
        if (bus.ready) begin
          if (bus.error) begin
            err_addr_d = dst_q;
            error_d    = 1'b1;
            state_d    = ABORT;
          end else begin
            src_d = fillMode ? src_q : srcNext;
            dst_d = dstNext;
            rem_d = remNext;
            if (remNext == '0) begin
              state_d = DONE;
            end else begin
              asize_d = nextAsize;
              state_d = fillMode ? WRITE : READ;
            end
          end
        end
      end

      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q == READ) || (state_q == WRITE);
  assign done_o     = (state_q == DONE) || (state_q == ABORT);
  assign error_o    = error_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_axo_dma_copy.sv
// ---------------------------------------------------------------------------
// tb_axo_dma_copy
// Self-checking bench for axo_dma_copy. A byte-addressed RAM responder with
// configurable wait states and error injection sits on the bus; a reference
// model derives expected accesses, memory contents and completion cycle.
// ---------------------------------------------------------------------------
module tb_axo_dma_copy;

`ifdef AXO_DMA_FILL_EN
  localparam bit FillEn = 1'b1;
`else
  localparam bit FillEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic        fill;
  logic [31:0] pattern;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] errAddr;

  axo_mem_bus bus();

  axo_dma_copy #(.len_bits(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .src_i     (src),
    .dst_i     (dst),
    .len_i     (len),
    .fill_i    (fill),
    .pattern_i (pattern),
    .busy_o    (busy),
    .done_o    (done),
    .error_o   (error),
    .err_addr_o(errAddr),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Responder state and configuration
  logic [7:0]  mem    [0:4095];
  logic [7:0]  refMem [0:4095];
  bit          memSeeded = 1'b0;
  int          waitCfg = 0;
  int          waitCnt = 0;
  bit          errEn = 1'b0;
  logic [31:0] errAt = '0;
  bit          errOnWrite = 1'b0;
  logic [34:0] accLog [$];
  logic [34:0] expAcc [$];
  int          stabViol = 0;
  int          protoViol = 0;
  bit          prevValid = 1'b0;
  logic [31:0] prevAddr;
  logic [31:0] prevWdata;
  logic [1:0]  prevAsize;
  logic        prevRe;
  logic        prevWe;

  wire active = bus.re | bus.we;

  assign bus.ready = active && (waitCnt >= waitCfg);
  assign bus.error = bus.ready && errEn && (bus.addr == errAt) &&
                     (errOnWrite ? bus.we : bus.re);

  // Right-justified read data from the byte RAM (addresses wrap at 4 KiB).
  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < 4; i++) bus.rdata[8*i +: 8] = mem[12'(bus.addr + 32'(i))];
  end

  // Responder: wait-state counter, access log, RAM writes and protocol monitor.
  always @(posedge clk) begin
    if (!rst_n && !memSeeded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'($urandom);
      memSeeded <= 1'b1;
    end
    if (active && bus.ready) begin
      waitCnt <= 0;
      accLog.push_back({bus.we, bus.asize, bus.addr});
      if (bus.we && !bus.error) begin
        for (int i = 0; i < 4; i++)
          if (i < (1 << bus.asize)) mem[12'(bus.addr + 32'(i))] <= bus.wdata[8*i +: 8];
      end
    end else if (active) begin
      waitCnt <= waitCnt + 1;
    end else begin
      waitCnt <= 0;
    end
    if (rst_n && prevValid &&
        (bus.addr !== prevAddr || bus.asize !== prevAsize || bus.re !== prevRe ||
         bus.we !== prevWe || (bus.we && bus.wdata !== prevWdata)))
      stabViol <= stabViol + 1;
    if ((bus.re && bus.we) || (active && ((bus.addr & ((32'd1 << bus.asize) - 32'd1)) != 0)))
      protoViol <= protoViol + 1;
    prevValid <= rst_n && active && !bus.ready;
    prevAddr  <= bus.addr;
    prevAsize <= bus.asize;
    prevRe    <= bus.re;
    prevWe    <= bus.we;
    prevWdata <= bus.wdata;
  end

  // Reference model: walks the transfer unit by unit from the sizing rules,
  // producing the expected access list and updating refMem.
  task automatic modelXfer(input logic [31:0] s, input logic [31:0] d, input int n,
                           input bit f, input logic [31:0] p);
    logic [31:0] sa = s;
    logic [31:0] da = d;
    int rem = n;
    int sz;
    logic [1:0] asz;
    expAcc.delete();
    while (rem > 0) begin
      if (da % 4 == 0 && (f || sa % 4 == 0) && rem >= 4)      sz = 4;
      else if (da % 2 == 0 && (f || sa % 2 == 0) && rem >= 2) sz = 2;
      else                                                    sz = 1;
      asz = (sz == 4) ? 2'd2 : (sz == 2) ? 2'd1 : 2'd0;
      if (!f) expAcc.push_back({1'b0, asz, sa});
      expAcc.push_back({1'b1, asz, da});
      for (int i = 0; i < sz; i++)
        refMem[12'(da + 32'(i))] = f ? p[8*i +: 8] : refMem[12'(sa + 32'(i))];
      if (!f) sa = sa + 32'(sz);
      da  = da + 32'(sz);
      rem = rem - sz;
    end
  endtask

  function automatic int logDiffs(input int base);
    int diffs = 0;
    if (accLog.size() - base != expAcc.size()) return 1000 + accLog.size() - base;
    for (int i = 0; i < expAcc.size(); i++)
      if (accLog[base + i] !== expAcc[i]) diffs++;
    return diffs;
  endfunction

  function automatic int memDiffs();
    int diffs = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== refMem[i]) diffs++;
    return diffs;
  endfunction

  // Issues one start and waits (bounded) for done; doneCycle counts cycles
  // after the start edge, 1 being the cycle right after it, -1 on timeout.
  task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                               input bit f, input logic [31:0] p,
                               output int doneCycle, output bit busyC1, output bit errC1);
    @(negedge clk);
    src = s; dst = d; len = n; fill = f; pattern = p; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    doneCycle = -1;
    busyC1 = 1'b0;
    errC1 = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        busyC1 = busy;
        errC1  = error;
      end
      if (done) begin
        doneCycle = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0; fill = 1'b0; pattern = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, error, bus.re, bus.we} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {busy, done, error, bus.re, bus.we});
    end
    checks++;
    if ({bus.addr, bus.wdata, errAddr, bus.asize} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_values: got addr=%h wdata=%h err_addr=%h expected all zero",
               bus.addr, bus.wdata, errAddr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_aligned_copy();
    int dc; bit b1; bit e1; int base;
    waitCfg = 0;
    refMem = mem;
    for (int i = 0; i < 8; i++) refMem[12'h200 + i] = refMem[12'h100 + i];
    expAcc = '{{1'b0, 2'd2, 32'h100}, {1'b1, 2'd2, 32'h200},
               {1'b0, 2'd2, 32'h104}, {1'b1, 2'd2, 32'h204}};
    base = accLog.size();
    applyStimulus(32'h100, 32'h200, 16'd8, 1'b0, 32'h0, dc, b1, e1);
    checks++;
    if (dc !== 5) begin
      failures++;
      $display("[TB] FAIL aligned_done_cycle: got %0d expected 5", dc);
    end
    checks++;
    if (b1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL aligned_busy: got %b expected 1", b1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_pulse_width: got done=%b expected 0", done);
    end
    checks++;
    if (logDiffs(base) !== 0) begin
      failures++;
      $display("[TB] FAIL aligned_accesses: got %0d differences expected 0", logDiffs(base));
    end
    checks++;
    if (memDiffs() !== 0) begin
      failures++;
      $display("[TB] FAIL aligned_memory: got %0d bad bytes expected 0", memDiffs());
    end
  endtask

  task automatic test_mixed_align();
    int dc; bit b1; bit e1; int base;
    waitCfg = 0;
    refMem = mem;
    for (int i = 0; i < 6; i++) refMem[12'h201 + i] = refMem[12'h101 + i];
    expAcc = '{{1'b0, 2'd0, 32'h101}, {1'b1, 2'd0, 32'h201},
               {1'b0, 2'd1, 32'h102}, {1'b1, 2'd1, 32'h202},
               {1'b0, 2'd1, 32'h104}, {1'b1, 2'd1, 32'h204},
               {1'b0, 2'd0, 32'h106}, {1'b1, 2'd0, 32'h206}};
    base = accLog.size();
    applyStimulus(32'h101, 32'h201, 16'd6, 1'b0, 32'h0, dc, b1, e1);
    checks++;
    if (logDiffs(base) !== 0) begin
      failures++;
      $display("[TB] FAIL mixed_accesses: got %0d differences expected 0", logDiffs(base));
    end
    checks++;
    if (memDiffs() !== 0 || error !== 1'b0 || dc !== 9) begin
      failures++;
      $display("[TB] FAIL mixed_result: got bad=%0d error=%b done_cycle=%0d expected 0 0 9",
               memDiffs(), error, dc);
    end
  endtask

  task automatic test_wait_states();
    int dc; bit b1; bit e1;
    waitCfg = 3;
    refMem = mem;
    for (int i = 0; i < 4; i++) refMem[12'h040 + i] = refMem[i];
    applyStimulus(32'h0, 32'h40, 16'd4, 1'b0, 32'h0, dc, b1, e1);
    checks++;
    if (dc !== 9) begin
      failures++;
      $display("[TB] FAIL wait_done_cycle: got %0d expected 9", dc);
    end
    checks++;
    if (stabViol !== 0 || memDiffs() !== 0) begin
      failures++;
      $display("[TB] FAIL wait_stability: got unstable=%0d bad=%0d expected 0 0", stabViol, memDiffs());
    end
    waitCfg = 0;
  endtask

  task automatic test_bus_error();
    int dc; bit b1; bit e1; int base;
    waitCfg = 0; errEn = 1'b1; errAt = 32'h204; errOnWrite = 1'b1;
    refMem = mem;
    for (int i = 0; i < 4; i++) refMem[12'h200 + i] = refMem[12'h100 + i];
    expAcc = '{{1'b0, 2'd2, 32'h100}, {1'b1, 2'd2, 32'h200},
               {1'b0, 2'd2, 32'h104}, {1'b1, 2'd2, 32'h204}};
    base = accLog.size();
    applyStimulus(32'h100, 32'h200, 16'd8, 1'b0, 32'h0, dc, b1, e1);
    checks++;
    if (dc !== 5 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL error_done: got done_cycle=%0d busy=%b expected 5 0", dc, busy);
    end
    checks++;
    if (error !== 1'b1 || errAddr !== 32'h204) begin
      failures++;
      $display("[TB] FAIL error_flag: got error=%b err_addr=%h expected 1 00000204", error, errAddr);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (logDiffs(base) !== 0 || memDiffs() !== 0) begin
      failures++;
      $display("[TB] FAIL error_no_more_access: got diffs=%0d bad=%0d expected 0 0",
               logDiffs(base), memDiffs());
    end
    errEn = 1'b0;
    refMem = mem;
    modelXfer(32'h300, 32'h400, 4, 1'b0, 32'h0);
    applyStimulus(32'h300, 32'h400, 16'd4, 1'b0, 32'h0, dc, b1, e1);
    checks++;
    if (e1 !== 1'b0 || error !== 1'b0 || dc !== 3) begin
      failures++;
      $display("[TB] FAIL error_cleared: got error=%b/%b done_cycle=%0d expected 0 0 3", e1, error, dc);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    waitCfg = 2;
    @(negedge clk);
    src = 32'h0; dst = 32'h500; len = 16'd8; fill = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.we) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL reset_mid_reach_write: got no write within 50 cycles expected one");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.we, bus.re, busy, done, error} !== 5'b0 || bus.addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: got we/re/busy/done/error=%b addr=%h expected 00000 0",
               {bus.we, bus.re, busy, done, error}, bus.addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    waitCfg = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || active !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_idle: got busy=%b active=%b expected 0 0", busy, active);
    end
  endtask

  task automatic test_len_zero();
    int dc; bit b1; bit e1; int base;
    base = accLog.size();
    applyStimulus(32'h10, 32'h20, 16'd0, 1'b0, 32'h0, dc, b1, e1);
    repeat (2) @(negedge clk);
    checks++;
    if (dc !== 1 || b1 !== 1'b0 || accLog.size() !== base) begin
      failures++;
      $display("[TB] FAIL len_zero: got done_cycle=%0d busy=%b accesses=%0d expected 1 0 0",
               dc, b1, accLog.size() - base);
    end
  endtask

  task automatic test_fill();
    int dc; bit b1; bit e1; int base; int expCycle;
    logic [31:0] pat;
    pat = 32'hDEADBEEF;
    waitCfg = 0;
    refMem = mem;
    if (FillEn) begin
      for (int i = 0; i < 8; i++) refMem[12'h300 + i] = pat[8*(i%4) +: 8];
      expAcc = '{{1'b1, 2'd2, 32'h300}, {1'b1, 2'd2, 32'h304}};
      expCycle = 3;
    end else begin
      for (int i = 0; i < 8; i++) refMem[12'h300 + i] = refMem[12'h100 + i];
      expAcc = '{{1'b0, 2'd2, 32'h100}, {1'b1, 2'd2, 32'h300},
                 {1'b0, 2'd2, 32'h104}, {1'b1, 2'd2, 32'h304}};
      expCycle = 5;
    end
    base = accLog.size();
    applyStimulus(32'h100, 32'h300, 16'd8, 1'b1, pat, dc, b1, e1);
    checks++;
    if (dc !== expCycle || logDiffs(base) !== 0) begin
      failures++;
      $display("[TB] FAIL fill_accesses: got done_cycle=%0d diffs=%0d expected %0d 0",
               dc, logDiffs(base), expCycle);
    end
    checks++;
    if (memDiffs() !== 0) begin
      failures++;
      $display("[TB] FAIL fill_memory: got %0d bad bytes expected 0", memDiffs());
    end
  endtask

  task automatic test_random();
    int dc; bit b1; bit e1; int base; int expCycle;
    logic [31:0] s, d, p;
    int n;
    bit f;
    for (int it = 0; it < 24; it++) begin
      s = 32'($urandom_range(0, 32'h3FF));
      d = 32'h800 + 32'($urandom_range(0, 32'h3FF));
      n = $urandom_range(0, 40);
      f = 1'($urandom_range(0, 1));
      p = $urandom;
      if (it == 0) begin
        s = 32'hFFFF_FFFE; d = 32'h0000_0902; n = 6; f = 1'b0;
      end
      waitCfg = $urandom_range(0, 2);
      refMem = mem;
      modelXfer(s, d, n, f && FillEn, p);
      expCycle = (n == 0) ? 1 : 1 + expAcc.size() * (1 + waitCfg);
      base = accLog.size();
      applyStimulus(s, d, 16'(n), f, p, dc, b1, e1);
      checks++;
      if (dc !== expCycle || error !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rand_timing it=%0d: got done_cycle=%0d error=%b expected %0d 0",
                 it, dc, error, expCycle);
      end
      checks++;
      if (logDiffs(base) !== 0 || memDiffs() !== 0) begin
        failures++;
        $display("[TB] FAIL rand_data it=%0d: got diffs=%0d bad=%0d expected 0 0",
                 it, logDiffs(base), memDiffs());
      end
    end
    waitCfg = 0;
    checks++;
    if (stabViol !== 0 || protoViol !== 0) begin
      failures++;
      $display("[TB] FAIL bus_protocol: got unstable=%0d illegal=%0d expected 0 0", stabViol, protoViol);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_copy();
    test_mixed_align();
    test_wait_states();
    test_bus_error();
    test_reset_mid();
    test_len_zero();
    test_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Global time bound in case a wait loop is ever defeated.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axo_dma_copy.md
# axo_dma_copy

Single-channel memory-copy engine acting as an initiator on the Axo memory bus. It moves `len` bytes from `src` to `dst` through any Axo bus responder, such as the aligned block-RAM responders. For each transfer unit it picks the widest naturally aligned access size the current addresses and remaining length allow. It sits beside the CPU as a bus initiator; bus arbitration is outside this block.

## Interface
- `len_bits`, default 16: width of the byte-count input and of the internal remaining-length counter.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `src`  in  32  source byte address, sampled on an accepted `start`.
- `dst`  in  32  destination byte address, sampled on an accepted `start`.
- `len`  in  `len_bits`  byte count, sampled on an accepted `start`.
- `fill`  in  1  fill mode select, sampled on an accepted `start` (see Configuration).
- `pattern`  in  32  fill data, sampled on an accepted `start`.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse on completion or abort.
- `error`  out  1  sticky abort flag; cleared on the next accepted `start`.
- `err_addr`  out  32  address of the faulting access.
- `bus`  `axo_mem_bus.CPU`  initiator side of the Axo memory bus: `addr`, `asize`, `re`, `we`, `wdata` driven; `rdata`, `ready`, `error` sampled.

## Operation
- The FSM states are IDLE, READ, WRITE, DONE and ABORT.
- **IDLE**
  - `start`=1 latches `src`, `dst`, `len`, `fill` and `pattern`, clears `error`, and sets `busy`.
  - If `len`=0, go to DONE.
  - Otherwise go to READ, or to WRITE when fill is active.
  - `start` outside IDLE is ignored.
- **Unit size** n, in bytes, is recomputed at every entry to READ or to WRITE-from-fill:
  - n=4 when src[1:0]=0, dst[1:0]=0 and rem≥4. `asize`=2.
  - Else n=2 when src[0]=0, dst[0]=0 and rem≥2. `asize`=1.
  - Else n=1. `asize`=0.
  - In fill mode the src terms are ignored.
- **READ**
  - Drive `addr`=src, `asize`, `re`=1 and `we`=0. Hold them until `ready`=1.
  - On `ready`=1 with `bus.error`=0: capture `rdata` into the low n bytes of the data register, then go to WRITE.
- **WRITE**
  - Drive `addr`=dst, the same `asize`, `we`=1, `re`=0, and `wdata` = data register (pattern in fill mode). Only the low 8n bits are significant.
  - On `ready`=1 with `bus.error`=0: src+=n (not in fill mode), dst+=n, rem-=n.
  - Next state: DONE if rem reaches 0, else READ (fill: WRITE).
- Address arithmetic is modulo 2^32; wrap-around past 0xFFFFFFFF is legal and not an error.
- **Bus error**: `ready`=1 with `bus.error`=1 in READ or WRITE.
  - Set `err_addr` to the current `addr` and set `error`=1.
  - Go to ABORT. No further accesses are issued; rem, src and dst freeze.
- **DONE / ABORT** last one cycle each: `done`=1, `busy`=0 in that cycle, then IDLE.
- `re` and `we` are never both high, and both are low outside READ/WRITE.
- **Reset** (`rst_n` low), including mid-transfer:
  - `re`, `we`, `busy`, `done` and `error` go to 0 immediately.
  - `addr`, `asize`, `wdata` and `err_addr` go to 0.
  - FSM goes to IDLE. A partially written destination is left as is.

## Timing
- An accepted `start` at edge k gives `busy`=1 from k.
- The first bus access is presented in the cycle after edge k.
- With a zero-wait responder (`ready` combinationally 1):
  - Copy mode costs 2 cycles per unit.
  - Fill mode costs 1 cycle per unit.
  - `done` pulses in the cycle after the last write is accepted.
- Wait states extend the current state. `addr`, `asize`, `wdata`, `re` and `we` are stable while `ready`=0.
- `len`=0: `done` pulses in the cycle after k with no bus activity.
- `rdata` is sampled only on the edge where `ready`=1 in READ.

## Configuration
- `AXO_DMA_FILL_EN` defined:
  - `fill` and `pattern` are honoured.
  - Fill mode writes `pattern` repeatedly to dst without reads.
- `AXO_DMA_FILL_EN` undefined:
  - The ports remain but `fill` is treated as 0 and `pattern` is unused.
  - Every transfer is a copy; the fill datapath is not synthesized.

## Test plan
- **Aligned copy**: src=0x100, dst=0x200, len=8, zero-wait RAM.
  - Expect four accesses: R4 0x100, W4 0x200, R4 0x104, W4 0x204.
  - `done` 5 cycles after the start edge; dst words match src.
- **Mixed alignment**: src=0x101, dst=0x201, len=6.
  - Expect units sized 1, 2, 2, 1 (the 2-byte units fall at offsets 0x102 and 0x104).
  - Expect no misaligned access and no bus error; the 6 bytes are copied exactly.
- **Wait states**: responder holds `ready`=0 for 3 cycles per access, src=0x0, dst=0x40, len=4.
  - `addr`, `re` and `we` stay stable throughout; `done` comes 8 cycles after issue of the first access.
- **Bus error**: responder errors on the write to 0x204 during an 8-byte copy.
  - Expect `error`=1, `err_addr`=0x204, `done` pulse, and no further accesses.
  - A new `start` clears `error`.
- **Reset mid-transfer and len=0**:
  - Deassert `rst_n` during WRITE: `we`=0 and `busy`=0 immediately, FSM in IDLE.
  - Then start with len=0: `done` next cycle, no `re`/`we`.
- **Fill** (with `AXO_DMA_FILL_EN`): dst=0x300, len=8, pattern=0xDEADBEEF.
  - Two W4 writes only; both words read back 0xDEADBEEF.
  - Without the macro, the same stimulus performs a copy from src.
